dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder with valid/ready on both sides.
// Accepts one load/store at a time, answers LATENCY cycles later, holds the
// response until consumed.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_valid   request present            req_ready  request accepted (IDLE)
//   req_we      1 = store, 0 = load        req_funct3 RV32I width/sign code
//   req_addr    byte address               req_wdata  LSB-aligned store data
//   rsp_valid   response present           rsp_ready  response consumed
//   rsp_rdata   extended load result       rsp_err    request faulted
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Storage is deliberately left without reset.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          f3_bad;
    logic          misal;
    logic          oor;
    logic          fault;
    logic          mem_we;

    assign idx     = addr_q[AW+1:2];
    assign lane    = addr_q[1:0];
    assign word    = mem_q[idx];
    assign shifted = word >> {lane, 3'b000};
    assign oor     = |addr_q[31:AW+2];
    assign fault   = f3_bad | misal | oor;

    // Legality and alignment of the captured request.
    always_comb begin
        f3_bad = 1'b0;
        misal  = 1'b0;
        unique case (f3_q)
            3'b000: f3_bad = 1'b0;
            3'b001: misal  = addr_q[0];
            3'b010: misal  = |addr_q[1:0];
            3'b100: f3_bad = we_q;
            3'b101: begin
                f3_bad = we_q;
                misal  = addr_q[0];
            end
            default: f3_bad = 1'b1;
        endcase
    end

    // Load extraction from the lane-shifted word.
    always_comb begin
        ld_data = 32'h0;
        unique case (f3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  ld_data = shifted;
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

    // Store lanes: data is replicated so every enabled lane sees it.
    always_comb begin
        be = 4'b0000;
        wd = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = fault;
                    rdata_d = (fault || we_q) ? 32'h0 : ld_data;
                    mem_we  = we_q & ~fault;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // mem_we is only raised from BUSY, so an asynchronous reset that drops
    // the state to IDLE also cancels a pending store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors, corner sequences and a randomized
// run against a byte-level reference model.
module tb_dmem_responder;

    localparam int DW = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        r1_valid, r1_ready, r1_we;
    logic [2:0]  r1_f3;
    logic [31:0] r1_addr, r1_wdata;
    logic        r1_rvalid, r1_rready, r1_err;
    logic [31:0] r1_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mref [256];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tv [$];

    dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(r1_valid), .req_ready(r1_ready),
        .req_we(r1_we), .req_funct3(r1_f3),
        .req_addr(r1_addr), .req_wdata(r1_wdata),
        .rsp_valid(r1_rvalid), .rsp_ready(r1_rready),
        .rsp_rdata(r1_rdata), .rsp_err(r1_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Starts and ends at a falling edge with the DUT idle.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int lat);
        int k;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        lat = k;
        rd  = rsp_rdata;
        er  = rsp_err;
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one");
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_rsp", {30'b0, rsp_valid, req_ready}, 32'd1);
        chk("rdata_hold", rsp_rdata, rd);
    endtask

    task automatic ref_model(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er);
        int  size;
        bit  sgn;
        bit  legal;
        rd    = 32'h0;
        legal = (f3 inside {3'd0, 3'd1, 3'd2}) ||
                ((f3 inside {3'd4, 3'd5}) && !we);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        sgn   = !f3[2];
        er    = !legal || ((addr % size) != 0) || (addr >= 32'(DW * 4));
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++)
                    mref[8'(addr + i)] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++)
                    rd = rd | (32'(mref[8'(addr + i)]) << (8 * i));
                if (sgn && size < 4 && rd[8*size-1])
                    rd = rd | (32'hFFFF_FFFF << (8 * size));
            end
        end
    endtask

    initial begin
        logic [31:0] rd, erd, snap;
        logic        er, eer;
        int          lat, k;
        logic [2:0]  legal_f3 [5];
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;

        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        tv.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        tv.push_back('{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0});
        tv.push_back('{1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0});
        tv.push_back('{1'b0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0});
        tv.push_back('{1'b0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 1'b0});
        tv.push_back('{1'b1, 3'b010, 32'h20,   32'h11223344, 32'h0,        1'b0});
        tv.push_back('{1'b1, 3'b000, 32'h21,   32'h000000AA, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 32'h20,   32'h0,        32'h1122AA44, 1'b0});
        tv.push_back('{1'b1, 3'b001, 32'h22,   32'h0000BBCC, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 32'h20,   32'h0,        32'hBBCCAA44, 1'b0});
        tv.push_back('{1'b1, 3'b010, 32'h0,    32'h55AA55AA, 32'h0,        1'b0});
        tv.push_back('{1'b1, 3'b010, 32'h40,   32'hCAFEF00D, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 32'h41,   32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0});
        tv.push_back('{1'b1, 3'b001, 32'h43,   32'h00001234, 32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0});
        tv.push_back('{1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b010, 32'h0,    32'h0,        32'h55AA55AA, 1'b0});
        tv.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0});
        tv.push_back('{1'b0, 3'b011, 32'h40,   32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b1, 3'b011, 32'h40,   32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b1, 3'b100, 32'h40,   32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0});
        tv.push_back('{1'b0, 3'b110, 32'h40,   32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b101, 32'h41,   32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b100, 32'h42,   32'h0,        32'h000000FE, 1'b0});

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        r1_valid   = 1'b0;
        r1_we      = 1'b0;
        r1_f3      = 3'b000;
        r1_addr    = 32'h0;
        r1_wdata   = 32'h0;
        r1_rready  = 1'b1;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            do_req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
        end

        // Backpressure with an intruding request during RESP.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("bp_lat", 32'(k), 32'd2);
        snap = rsp_rdata;
        chk("bp_data", snap, 32'hDEADBEEF);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, snap);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_exit", {30'b0, rsp_valid, req_ready}, 32'd1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        chk("bp_no_intrude", rd, 32'hDEADBEEF);

        // Reset while a store is pending.
        do_req(1'b1, 3'b010, 32'h50, 32'hA5A5A5A5, rd, er, lat);
        do_req(1'b0, 3'b010, 32'h50, 32'h0, rd, er, lat);
        chk("rst_pre_load", rd, 32'hA5A5A5A5);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h50;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_busy", {30'b0, rsp_valid, req_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(rsp_valid), 32'd0);
        chk("rst_async_rdata", rsp_rdata, 32'h0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h50;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h50, 32'h0, rd, er, lat);
        chk("rst_store_dropped", rd, 32'hA5A5A5A5);
        chk("rst_first_lat", 32'(lat), 32'd2);
        do_req(1'b1, 3'b010, 32'h50, 32'h0, rd, er, lat);
        do_req(1'b0, 3'b010, 32'h50, 32'h0, rd, er, lat);
        chk("rst_reload", rd, 32'h0);

        // Single-cycle latency instance.
        for (int j = 0; j < 3; j++) begin
            r1_valid = 1'b1;
            r1_we    = (j == 0);
            r1_f3    = (j == 2) ? 3'b000 : 3'b010;
            r1_addr  = (j == 2) ? 32'h9 : 32'h8;
            r1_wdata = 32'h13579BDF;
            @(posedge clk);
            @(negedge clk);
            r1_valid = 1'b0;
            k = 0;
            while (!r1_rvalid && k < 40) begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
            chk($sformatf("lat1_%0d_lat", j), 32'(k), 32'd1);
            erd = (j == 0) ? 32'h0 : (j == 1) ? 32'h13579BDF : 32'hFFFFFF9B;
            chk($sformatf("lat1_%0d_rdata", j), r1_rdata, erd);
            @(posedge clk);
            @(negedge clk);
        end

        // Randomized run against the byte model.
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            ref_model(1'b1, 3'b010, 32'(w * 4), wd, erd, eer);
            do_req(1'b1, 3'b010, 32'(w * 4), wd, rd, er, lat);
        end
        for (int n = 0; n < 300; n++) begin
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0)
                f3 = legal_f3[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom);
            if ($urandom_range(0, 9) == 0)
                addr = 32'(DW * 4) + 32'($urandom_range(0, 255));
            else
                addr = 32'($urandom_range(0, 255));
            wd = $urandom;
            ref_model(we, f3, addr, wd, erd, eer);
            do_req(we, f3, addr, wd, rd, er, lat);
            chk($sformatf("rnd%0d_rdata", n), rd, erd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(eer));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
